hex_display_arbiter: RTL and testbench
======================================

// Module: hex_display_arbiter
// PURPOSE
//  Shares the 6-digit hex display between two requesters: the Nios CPU (24-bit pio_7seg word)
//  and a hardware overlay source (e.g. switch/status monitor). Sits between the platform
//  instance and the six seven_segment_driver instances in the top level.
//  Overlay gets timed exclusive ownership, then a guard window guarantees CPU visibility.
// PARAMETERS
//  HOLD_CYCLES   50_000_000  cycles the overlay word is shown per grant (>=2)
//  GUARD_CYCLES  25_000_000  cycles CPU word is shown after an overlay before the next grant (>=1)
//  BLINK_CYCLES  12_500_000  half-period of overlay blink (BLINK_EN only, >=1)
// PORTS
//  clk_50      in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  cpu_data    in   24  CPU nibble word, digit n = [4n+3:4n]
//  cpu_valid   in   1   1-cycle strobe: latch cpu_data
//  ovr_req     in   1   overlay request (level)
//  ovr_data    in   24  overlay nibble word, sampled at grant
//  ovr_ack     out  1   1-cycle pulse: overlay granted, ovr_data captured
//  blank_mask  in   6   per-digit blank request, bit n blanks digit n
//  disp_data   out  24  word to seven_segment_drivers
//  disp_blank  out  6   per-digit blank to drivers (1 = dark)
//  owner       out  1   0 = CPU word shown, 1 = overlay shown
//  busy        out  1   1 when state != S_CPU
// BEHAVIOUR
//  - All outputs registered on clk_50. Reset is synchronous and active-high. On reset:
//    state=S_CPU, cpu latch=0, disp_data=0, disp_blank=0, owner=0, ovr_ack=0, busy=0.
//  - cpu latch: cpu_valid=1 at edge -> latch=cpu_data, in every state. A new word never
//    interrupts an overlay.
//  - States:
//    S_CPU:   disp_data<=cpu latch. ovr_req=1 -> S_OVR, capture ovr_data, ovr_ack<=1,
//             timer<=HOLD_CYCLES-1.
//    S_OVR:   disp_data<=captured overlay word, owner=1. ovr_req ignored.
//             Timer decrements each cycle. At 0 -> S_GUARD, timer<=GUARD_CYCLES-1.
//    S_GUARD: disp_data<=cpu latch, owner=0. ovr_req ignored. At 0 -> S_CPU.
//  - Overlay is shown exactly HOLD_CYCLES cycles. Guard lasts exactly GUARD_CYCLES cycles.
//    Minimum request-to-request spacing is HOLD_CYCLES+GUARD_CYCLES+1 cycles.
//  - Latency: cpu_valid at edge T -> disp_data updated at edge T+1 (S_CPU/S_GUARD).
//    Grant: ovr_req sampled at edge T -> ovr_ack/owner/disp_data valid after edge T.
//  - ovr_ack is high for exactly one cycle per grant. A held ovr_req re-grants only after
//    the guard ends (fairness).
//  - Simultaneous cpu_valid and grant in S_CPU: overlay shown, CPU latch still updated,
//    and the new CPU word appears when S_GUARD is entered.
//  - disp_blank<=blank_mask (1-cycle registered) in all states, except as modified below.
//  - Timer width $clog2(max(HOLD,GUARD,BLINK)) bits. No wrap: reloaded on every state entry.
//  - Reset mid-overlay: next state S_CPU, overlay word discarded, no ovr_ack issued.
// CONFIGURATION
//  - HEX_ARB_BLINK_EN defined: in S_OVR a blink counter (reload BLINK_CYCLES-1) toggles a
//    phase bit. It is cleared at grant, so the first half-period is lit. Phase=1 ->
//    disp_blank=6'h3F, else blank_mask. Outside S_OVR, phase is held 0.
//  - Undefined: no blink logic. disp_blank = registered blank_mask always.
// TESTING  (HOLD_CYCLES=8, GUARD_CYCLES=4, BLINK_CYCLES=2)
//  - reset 3 cycles -> disp_data=0, disp_blank=0, owner=0, busy=0, ovr_ack=0.
//  - cpu_valid, cpu_data=24'h123456 -> next cycle disp_data=24'h123456, owner=0.
//  - ovr_req=1 held, ovr_data=24'hABCDEF -> single ovr_ack pulse; ABCDEF shown 8 cycles;
//    then 123456 for 4 cycles; then second ovr_ack.
//  - cpu_valid 24'h000042 during S_OVR -> display stays ABCDEF; 000042 appears on guard entry.
//  - reset asserted 3 cycles into S_OVR -> next cycle state S_CPU, disp_data=0, busy=0.
//  - blank_mask=6'b000011 -> disp_blank=6'b000011 in S_CPU. With HEX_ARB_BLINK_EN, S_OVR
//    pattern is 000011,000011,3F,3F repeating.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - shares the 6-digit hex display between the CPU word and a timed overlay.
// Optional overlay blink is enabled by defining HEX_ARB_BLINK_EN.
module hex_display_arbiter #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int GUARD_CYCLES = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [23:0] cpu_data,
  input  logic        cpu_valid,
  input  logic        ovr_req,
  input  logic [23:0] ovr_data,
  output logic        ovr_ack,
  input  logic [5:0]  blank_mask,
  output logic [23:0] disp_data,
  output logic [5:0]  disp_blank,
  output logic        owner,
  output logic        busy
);

  localparam int MAX_HG = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
  localparam int MAX_C  = (MAX_HG > BLINK_CYCLES) ? MAX_HG : BLINK_CYCLES;
  localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_OVR   = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t        r_state;
  logic [23:0]   r_cpu_latch;
  logic [TW-1:0] r_timer;

`ifdef HEX_ARB_BLINK_EN
  localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_CYCLES - 1);
  logic          r_phase;
  logic [TW-1:0] r_blink_cnt;
`endif

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state     <= S_CPU;
      r_cpu_latch <= 24'h0;
      r_timer     <= '0;
      disp_data   <= 24'h0;
      disp_blank  <= 6'h0;
      owner       <= 1'b0;
      ovr_ack     <= 1'b0;
      busy        <= 1'b0;
`ifdef HEX_ARB_BLINK_EN
      r_phase     <= 1'b0;
      r_blink_cnt <= '0;
`endif
    end else begin
      if (cpu_valid)
        r_cpu_latch <= cpu_data;
      ovr_ack    <= 1'b0;
      disp_blank <= blank_mask;

      case (r_state)
        S_CPU: begin
          disp_data <= r_cpu_latch;
          owner     <= 1'b0;
          busy      <= 1'b0;
          if (ovr_req) begin
            r_state   <= S_OVR;
            disp_data <= ovr_data;
            ovr_ack   <= 1'b1;
            owner     <= 1'b1;
            busy      <= 1'b1;
            r_timer   <= HOLD_LOAD;
`ifdef HEX_ARB_BLINK_EN
            r_phase     <= 1'b0;
            r_blink_cnt <= BLINK_LOAD;
`endif
          end
        end

        // disp_data already holds the overlay word captured at grant
        S_OVR: begin
          if (r_timer == '0) begin
            r_state   <= S_GUARD;
            disp_data <= r_cpu_latch;
            owner     <= 1'b0;
            r_timer   <= GUARD_LOAD;
`ifdef HEX_ARB_BLINK_EN
            r_phase   <= 1'b0;
`endif
          end else begin
            r_timer <= r_timer - 1'b1;
`ifdef HEX_ARB_BLINK_EN
            // Blank follows the phase that will be in effect for the coming cycle
            if (r_blink_cnt == '0) begin
              r_phase     <= ~r_phase;
              r_blink_cnt <= BLINK_LOAD;
              if (!r_phase)
                disp_blank <= 6'h3F;
            end else begin
              r_blink_cnt <= r_blink_cnt - 1'b1;
              if (r_phase)
                disp_blank <= 6'h3F;
            end
`endif
          end
        end

        S_GUARD: begin
          disp_data <= r_cpu_latch;
          owner     <= 1'b0;
          if (r_timer == '0) begin
            r_state <= S_CPU;
            busy    <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        default: begin
          r_state <= S_CPU;
          busy    <= 1'b0;
          owner   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - table-driven bench for hex_display_arbiter (HOLD=8, GUARD=4, BLINK=2).
module tb_hex_display_arbiter;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [23:0] cpu_data;
  logic        cpu_valid;
  logic        ovr_req;
  logic [23:0] ovr_data;
  logic        ovr_ack;
  logic [5:0]  blank_mask;
  logic [23:0] disp_data;
  logic [5:0]  disp_blank;
  logic        owner;
  logic        busy;

  always #5 clk_50 = ~clk_50;

  hex_display_arbiter #(
    .HOLD_CYCLES  (8),
    .GUARD_CYCLES (4),
    .BLINK_CYCLES (2)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .cpu_data   (cpu_data),
    .cpu_valid  (cpu_valid),
    .ovr_req    (ovr_req),
    .ovr_data   (ovr_data),
    .ovr_ack    (ovr_ack),
    .blank_mask (blank_mask),
    .disp_data  (disp_data),
    .disp_blank (disp_blank),
    .owner      (owner),
    .busy       (busy)
  );

`ifdef HEX_ARB_BLINK_EN
  localparam logic [5:0] DARK = 6'h3F;
`else
  localparam logic [5:0] DARK = 6'h03;
`endif

  typedef struct {
    logic        rst;
    logic        cv;
    logic [23:0] cd;
    logic        orq;
    logic [23:0] od;
    logic [5:0]  bm;
    logic [23:0] e_data;
    logic [5:0]  e_blank;
    logic        e_owner;
    logic        e_busy;
    logic        e_ack;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic cv, input logic [23:0] cd,
                     input logic orq, input logic [23:0] od, input logic [5:0] bm,
                     input logic [23:0] ed, input logic [5:0] eb,
                     input logic eo, input logic ebusy, input logic eack);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cd = cd; v.orq = orq; v.od = od; v.bm = bm;
    v.e_data = ed; v.e_blank = eb; v.e_owner = eo; v.e_busy = ebusy; v.e_ack = eack;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic cv, input logic [23:0] cd,
                       input logic orq, input logic [23:0] od, input logic [5:0] bm);
    reset = rst; cpu_valid = cv; cpu_data = cd; ovr_req = orq; ovr_data = od; blank_mask = bm;
  endtask

  task automatic tick;
    @(posedge clk_50);
    #1;
  endtask

  initial begin
    int acks;
    int first_ack;
    int last_ack;
    int prev_ack;
    int gap;
    bit done;

    drive(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 6'h0);

    // rst cv cd         orq od         bm      e_data      e_blank e_own busy ack
    add(1, 0, 24'h0,      0, 24'h0,      6'h00, 24'h000000, 6'h00, 0, 0, 0);
    add(1, 0, 24'h0,      0, 24'h0,      6'h00, 24'h000000, 6'h00, 0, 0, 0);
    add(1, 0, 24'h0,      0, 24'h0,      6'h00, 24'h000000, 6'h00, 0, 0, 0);
    add(0, 1, 24'h123456, 0, 24'h0,      6'h03, 24'h000000, 6'h03, 0, 0, 0);
    add(0, 0, 24'h0,      0, 24'h0,      6'h03, 24'h123456, 6'h03, 0, 0, 0);
    add(0, 0, 24'h0,      1, 24'hABCDEF, 6'h03, 24'hABCDEF, 6'h03, 1, 1, 1);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'hABCDEF, 6'h03, 1, 1, 0);
    add(0, 1, 24'h000042, 1, 24'h0,      6'h03, 24'hABCDEF, DARK,  1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'hABCDEF, DARK,  1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'hABCDEF, 6'h03, 1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'hABCDEF, 6'h03, 1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'hABCDEF, DARK,  1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'hABCDEF, DARK,  1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'h000042, 6'h03, 0, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'h000042, 6'h03, 0, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'h000042, 6'h03, 0, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'h000042, 6'h03, 0, 1, 0);
    add(0, 0, 24'h0,      1, 24'h654321, 6'h03, 24'h000042, 6'h03, 0, 0, 0);
    add(0, 0, 24'h0,      1, 24'h654321, 6'h03, 24'h654321, 6'h03, 1, 1, 1);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'h654321, 6'h03, 1, 1, 0);
    add(0, 0, 24'h0,      1, 24'h0,      6'h03, 24'h654321, DARK,  1, 1, 0);
    add(1, 0, 24'h0,      1, 24'h0,      6'h03, 24'h000000, 6'h00, 0, 0, 0);
    add(0, 0, 24'h0,      0, 24'h0,      6'h03, 24'h000000, 6'h03, 0, 0, 0);
    add(0, 0, 24'h0,      0, 24'h0,      6'h2A, 24'h000000, 6'h2A, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].cv, vecs[i].cd, vecs[i].orq, vecs[i].od, vecs[i].bm);
      tick();
      n_tests++;
      if (disp_data !== vecs[i].e_data || disp_blank !== vecs[i].e_blank ||
          owner !== vecs[i].e_owner || busy !== vecs[i].e_busy || ovr_ack !== vecs[i].e_ack) begin
        n_fail++;
        $display("FAIL vec%0d: got data=%h blank=%h owner=%b busy=%b ack=%b, want data=%h blank=%h owner=%b busy=%b ack=%b",
                 i, disp_data, disp_blank, owner, busy, ovr_ack,
                 vecs[i].e_data, vecs[i].e_blank, vecs[i].e_owner, vecs[i].e_busy, vecs[i].e_ack);
      end
    end

    // Held request: grants every HOLD+GUARD+1 = 13 cycles, exactly one ack per grant
    acks = 0; first_ack = -1; last_ack = -1; prev_ack = -1;
    drive(1'b0, 1'b0, 24'h0, 1'b1, 24'h111111, 6'h00);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ovr_ack === 1'b1) begin
        acks++;
        prev_ack = last_ack;
        last_ack = c;
        if (first_ack < 0) first_ack = c;
      end
    end
    gap = last_ack - prev_ack;
    n_tests++;
    if (acks != 4 || first_ack != 0) begin
      n_fail++;
      $display("FAIL held_req_acks: got count=%0d first=%0d, want count=4 first=0", acks, first_ack);
    end
    n_tests++;
    if (gap != 13) begin
      n_fail++;
      $display("FAIL held_req_spacing: got gap=%0d, want 13", gap);
    end

    // Release and wait (bounded) for return to S_CPU; last grant was at c=39
    drive(1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 6'h00);
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (busy === 1'b0) begin
        done = 1'b1;
        n_tests++;
        if (c != 11) begin
          n_fail++;
          $display("FAIL release_idle: got busy low after %0d cycles, want 11", c);
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL release_timeout: got busy=%b after 30 cycles, want 0", busy);
    end

    n_tests++;
    if (disp_data !== 24'h000000 || owner !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_word: got data=%h owner=%b, want data=000000 owner=0", disp_data, owner);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
